// File: rtl/aes_pipe_batch_ctrl.sv
// Batch sequencer for the half-pipelined AES core: optional key load, key-schedule
// settle wait, encrypt_go pulse, then block counting until the batch completes or faults.
module aes_pipe_batch_ctrl #(
  parameter int pCNT_W     = 16,
  parameter int pKEY_WAIT  = 24,
  parameter int pTIMEOUT_W = 20,
  parameter int pCYC_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_load_key,
  input  logic [pCNT_W-1:0] cmd_count,
  input  logic              cmd_abort,
  input  logic              pipe_busy,
  input  logic              block_out,
  input  logic [3:0]        fifo_errors,
  output logic              load_key,
  output logic              encrypt_go,
  output logic              clear_fifo_errors,
  output logic              trig_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic [2:0]        state_o,
  output logic [pCNT_W-1:0] blocks_done_o,
  output logic [pCYC_W-1:0] cycle_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_KEY   = 3'd2,
    ST_KWAIT = 3'd3,
    ST_GO    = 3'd4,
    ST_RUN   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_FIFO    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_t;

  localparam int KW_W = (pKEY_WAIT > 1) ? $clog2(pKEY_WAIT) : 1;
  localparam logic [KW_W-1:0]       KW_LAST = KW_W'(pKEY_WAIT - 1);
  localparam logic [pTIMEOUT_W-1:0] WD_MAX  = '1;
  // Watchdog fires on the edge that would carry it to all-ones.
  localparam logic [pTIMEOUT_W-1:0] WD_PRE  = WD_MAX - pTIMEOUT_W'(1);

  state_t              state_q, state_d;
  err_t                err_q, err_d;
  logic                done_q, done_d;
  logic [pCNT_W-1:0]   count_q;
  logic                key_q;
  logic [KW_W-1:0]     kw_q;
  logic [pTIMEOUT_W-1:0] wd_q;
  logic [pCNT_W-1:0]   blocks_q;
  logic [pCYC_W-1:0]   cyc_q;

  logic accept_start;
  logic blk_take;
  logic last_blk;
  logic batch_full;
  logic wd_expire;

  assign accept_start = cmd_start &&
                        (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign blk_take     = (state_q == ST_RUN) && block_out && (blocks_q != count_q);
  assign last_blk     = blk_take && ((blocks_q + pCNT_W'(1)) == count_q);
  assign batch_full   = (blocks_q == count_q) || last_blk;
  assign wd_expire    = !block_out && (wd_q == WD_PRE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (cmd_start) begin
          state_d = ST_CLR;
          err_d   = ERR_NONE;
          done_d  = 1'b0;
        end
      end
      ST_CLR: begin
        if (cmd_abort) begin
          state_d = ST_ERR;
          err_d   = ERR_ABORT;
        end else if (count_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (key_q) begin
          state_d = ST_KEY;
        end else begin
          state_d = ST_GO;
        end
      end
      ST_KEY: begin
        if (cmd_abort) begin
          state_d = ST_ERR;
          err_d   = ERR_ABORT;
        end else begin
          state_d = ST_KWAIT;
        end
      end
      ST_KWAIT: begin
        if (cmd_abort) begin
          state_d = ST_ERR;
          err_d   = ERR_ABORT;
        end else if (kw_q == KW_LAST) begin
          state_d = ST_GO;
        end
      end
      ST_GO: begin
        if (cmd_abort) begin
          state_d = ST_ERR;
          err_d   = ERR_ABORT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cmd_abort) begin
          state_d = ST_ERR;
          err_d   = ERR_ABORT;
        end else if (fifo_errors != 4'd0) begin
          state_d = ST_ERR;
          err_d   = ERR_FIFO;
        end else if (wd_expire) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end else if (batch_full && !pipe_busy) begin
          // Completion waits for the pipeline to drain before declaring DONE.
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      key_q    <= 1'b0;
      kw_q     <= '0;
      wd_q     <= '0;
      blocks_q <= '0;
      cyc_q    <= '0;
    end else begin
      if (accept_start) begin
        count_q  <= cmd_count;
        key_q    <= cmd_load_key;
        blocks_q <= '0;
        cyc_q    <= '0;
      end else begin
        if (blk_take) begin
          blocks_q <= blocks_q + pCNT_W'(1);
        end
        // Timing stops at the last counted block and saturates rather than wrapping.
        if ((state_q == ST_RUN) && (blocks_q != count_q) && (cyc_q != '1)) begin
          cyc_q <= cyc_q + pCYC_W'(1);
        end
      end

      if (state_q == ST_KWAIT) begin
        kw_q <= kw_q + KW_W'(1);
      end else begin
        kw_q <= '0;
      end

      if ((state_q == ST_RUN) && !block_out) begin
        wd_q <= wd_q + pTIMEOUT_W'(1);
      end else begin
        wd_q <= '0;
      end
    end
  end

  assign clear_fifo_errors = (state_q == ST_CLR);
  assign load_key          = (state_q == ST_KEY);
  assign encrypt_go        = (state_q == ST_GO);
  assign trig_o            = (state_q == ST_GO) || (state_q == ST_RUN);
  assign busy_o            = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign state_o           = state_q;
  assign blocks_done_o     = blocks_q;
  assign cycle_count_o     = cyc_q;

endmodule

// File: tb/tb_aes_pipe_batch_ctrl.sv
// Directed bench for aes_pipe_batch_ctrl; cycle numbers in comments count from the
// cycle in which cmd_start is high (cycle 0).
module tb_aes_pipe_batch_ctrl;

  localparam int CNT_W = 16;
  localparam int CYC_W = 32;

  logic             clk;
  logic             reset;
  logic             cmd_start;
  logic             cmd_load_key;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_abort;
  logic             pipe_busy;
  logic             block_out;
  logic [3:0]       fifo_errors;
  logic             load_key;
  logic             encrypt_go;
  logic             clear_fifo_errors;
  logic             trig_o;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       err_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] blocks_done_o;
  logic [CYC_W-1:0] cycle_count_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int go_cyc;
  int n_key;
  int n_pulse;

  aes_pipe_batch_ctrl #(
    .pCNT_W    (CNT_W),
    .pKEY_WAIT (24),
    .pTIMEOUT_W(6),
    .pCYC_W    (CYC_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_start        (cmd_start),
    .cmd_load_key     (cmd_load_key),
    .cmd_count        (cmd_count),
    .cmd_abort        (cmd_abort),
    .pipe_busy        (pipe_busy),
    .block_out        (block_out),
    .fifo_errors      (fifo_errors),
    .load_key         (load_key),
    .encrypt_go       (encrypt_go),
    .clear_fifo_errors(clear_fifo_errors),
    .trig_o           (trig_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .state_o          (state_o),
    .blocks_done_o    (blocks_done_o),
    .cycle_count_o    (cycle_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit: observed still running expected finished");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 1 of the new batch.
  task automatic start_batch(input logic key, input logic [CNT_W-1:0] cnt);
    cmd_start    = 1'b1;
    cmd_load_key = key;
    cmd_count    = cnt;
    step();
    cmd_start    = 1'b0;
    cmd_load_key = 1'b0;
    cmd_count    = '0;
  endtask

  task automatic pulse_block();
    block_out = 1'b1;
    step();
    block_out = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_load_key = 1'b0; cmd_count = '0;
    cmd_abort = 1'b0; pipe_busy = 1'b0; block_out = 1'b0; fifo_errors = 4'd0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_state", state_o, 0);
    check("rst_flags", {busy_o, trig_o, done_o, err_o, load_key, encrypt_go, clear_fifo_errors}, 0);
    check("rst_counts", {blocks_done_o, cycle_count_o}, 0);

    // Four blocks, no key, blocks at cycles 14/26/38/50, go at cycle 2.
    start_batch(1'b0, 16'd4);
    check("t1_clr_state", state_o, 1);
    check("t1_clr_pulse", {clear_fifo_errors, encrypt_go, busy_o}, 3'b101);
    step();
    check("t1_go", {state_o, encrypt_go, trig_o}, 5'b100_1_1);
    repeat (12) step();
    pulse_block();
    cmd_start = 1'b1; cmd_count = 16'd1; cmd_load_key = 1'b1;
    step();
    cmd_start = 1'b0; cmd_count = '0; cmd_load_key = 1'b0;
    check("t1_start_ignored", state_o, 5);
    repeat (10) step();
    pulse_block();
    check("t1_mid_blocks", blocks_done_o, 2);
    check("t1_mid_cycles", cycle_count_o, 24);
    repeat (11) step();
    pulse_block();
    repeat (11) step();
    check("t1_pre_last", {state_o, trig_o, done_o, busy_o}, 6'b101_1_0_1);
    pulse_block();
    check("t1_done", {state_o, done_o, err_o, busy_o, trig_o}, 8'b110_1_00_0_0);
    check("t1_blocks", blocks_done_o, 4);
    check("t1_cycles", cycle_count_o, 48);

    // One block while the pipeline stays busy; extra pulses are dropped.
    pipe_busy = 1'b1;
    start_batch(1'b0, 16'd1);
    check("t2_start_clears", {done_o, blocks_done_o, cycle_count_o}, 0);
    step();
    repeat (3) step();
    pulse_block();
    check("t2_hold_busy", {state_o, blocks_done_o}, {3'd5, 16'd1});
    pulse_block();
    check("t2_extra_dropped", blocks_done_o, 1);
    step();
    pipe_busy = 1'b0;
    step();
    check("t2_done", {state_o, done_o}, 4'b110_1);
    check("t2_cycles", cycle_count_o, 3);
    pulse_block();
    check("t2_done_hold", blocks_done_o, 1);

    // Key load: load_key at cycle 2, encrypt_go at cycle 27; fifo error in RUN.
    start_batch(1'b1, 16'd2);
    check("t3_clr_state", state_o, 1);
    step();
    check("t3_key", {state_o, load_key}, 4'b010_1);
    go_cyc = -1;
    n_key  = 0;
    for (int c = 3; c <= 40 && go_cyc < 0; c++) begin
      step();
      if (load_key === 1'b1) n_key++;
      if (encrypt_go === 1'b1) go_cyc = c;
    end
    check("t3_go_latency", go_cyc, 27);
    check("t3_single_key", n_key, 0);
    repeat (3) step();
    check("t3_run", state_o, 5);
    fifo_errors = 4'b0100;
    step();
    fifo_errors = 4'd0;
    check("t3_fifo_err", {state_o, err_o, trig_o, busy_o}, 7'b111_01_0_0);

    // Zero-length batch never pulses load_key or encrypt_go.
    start_batch(1'b1, 16'd0);
    check("t4_clr", {state_o, err_o, load_key}, 6'b001_00_0);
    step();
    check("t4_done", {state_o, done_o}, 4'b110_1);
    n_pulse = 0;
    repeat (5) begin
      step();
      if ((load_key | encrypt_go) === 1'b1) n_pulse++;
    end
    check("t4_no_pulses", n_pulse, 0);

    // Watchdog: 63 RUN cycles (3..65) without block_out.
    start_batch(1'b0, 16'd3);
    step();
    check("t5_go", encrypt_go, 1);
    repeat (63) step();
    check("t5_last_run", state_o, 5);
    step();
    check("t5_timeout", {state_o, err_o, busy_o}, 6'b111_10_0);
    check("t5_cycles", cycle_count_o, 63);

    // Abort during the key settle wait.
    start_batch(1'b1, 16'd2);
    step();
    step();
    repeat (5) step();
    check("t6_kwait", state_o, 3);
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    check("t6_abort", {state_o, err_o}, 5'b111_11);
    n_pulse = 0;
    repeat (30) begin
      step();
      if ((load_key | encrypt_go) === 1'b1) n_pulse++;
    end
    check("t6_no_pulses", n_pulse, 0);

    // Reset mid-RUN with 2 of 5 blocks done.
    start_batch(1'b0, 16'd5);
    step();
    repeat (2) step();
    pulse_block();
    pulse_block();
    check("t7_two_blocks", {state_o, blocks_done_o}, {3'd5, 16'd2});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7_rst_state", state_o, 0);
    check("t7_rst_flags", {busy_o, trig_o, done_o, err_o, load_key, encrypt_go, clear_fifo_errors}, 0);
    check("t7_rst_counts", {blocks_done_o, cycle_count_o}, 0);
    n_pulse = 0;
    repeat (10) begin
      step();
      if ((load_key | encrypt_go | busy_o) === 1'b1) n_pulse++;
    end
    check("t7_quiet", n_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
